// File: rtl/uart_tx_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_sched: round-robin (with lock/burst) byte scheduler feeding uart_tx.
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int p_num_req       = 4,
  parameter int p_max_burst     = 16,
  parameter int p_start_timeout = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [p_num_req-1:0]   req_valid_i,
  input  logic [8*p_num_req-1:0] req_data_i,
  input  logic [p_num_req-1:0]   req_lock_i,
  output logic [p_num_req-1:0]   req_ready_o,
  input  logic                   cfg_parity_en_i,
  input  logic                   cfg_parity_sel_i,
  input  logic                   cfg_stop_sel_i,
  output logic                   tx_enable_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_parity_en_o,
  output logic                   tx_parity_sel_o,
  output logic                   tx_stop_sel_o,
  input  logic                   tx_busy_i,
  output logic [p_num_req-1:0]   grant_o,
  output logic                   done_o,
  output logic [2:0]             done_id_o,
  output logic                   err_o
);

  localparam int IDX_W = (p_num_req > 1) ? $clog2(p_num_req) : 1;

  localparam logic [1:0] S_ARB       = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(p_num_req - 1);
  localparam logic [7:0]       MAX_BURST = 8'(p_max_burst);
  localparam logic [3:0]       TMO_LAST  = 4'(p_start_timeout - 1);

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic                 lock_q, lock_d;
  logic [7:0]           burst_q, burst_d;
  logic [3:0]           tmo_q, tmo_d;
  logic                 en_q, en_d;
  logic [7:0]           data_q, data_d;
  logic                 pen_q, pen_d;
  logic                 psel_q, psel_d;
  logic                 stop_q, stop_d;
  logic [p_num_req-1:0] grant_q, grant_d;
  logic                 done_q, done_d;
  logic [2:0]           done_id_q, done_id_d;
  logic                 err_q, err_d;

  logic                 arb_en;
  logic                 lock_eff;
  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx;
  logic [7:0]           burst_nx;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = (int'(base) + off) % p_num_req;
    return sum[IDX_W-1:0];
  endfunction

  // Arbitration is blocked during the done pulse so a new frame starts no
  // earlier than the cycle after it.
  always_comb begin
    arb_en   = (state_q == S_ARB) && !done_q && !rst_i;
    lock_eff = lock_q && req_lock_i[last_q];
    win_vld  = 1'b0;
    win_idx  = last_q;
    if (lock_eff) begin
      win_vld = req_valid_i[last_q];
    end else begin
      for (int i = p_num_req; i >= 1; i--) begin
        if (req_valid_i[rr_idx(last_q, i)]) begin
          win_vld = 1'b1;
          win_idx = rr_idx(last_q, i);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_ARB;
      last_q    <= LAST_RST;
      lock_q    <= 1'b0;
      burst_q   <= 8'd0;
      tmo_q     <= 4'd0;
      en_q      <= 1'b0;
      data_q    <= 8'd0;
      pen_q     <= 1'b0;
      psel_q    <= 1'b0;
      stop_q    <= 1'b0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      done_id_q <= 3'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      lock_q    <= lock_d;
      burst_q   <= burst_d;
      tmo_q     <= tmo_d;
      en_q      <= en_d;
      data_q    <= data_d;
      pen_q     <= pen_d;
      psel_q    <= psel_d;
      stop_q    <= stop_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ARB:       if (arb_en && win_vld) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy_i)              state_d = S_WAIT_DONE;
        else if (tmo_q == TMO_LAST) state_d = S_ARB;
      end
      S_WAIT_DONE: if (!tx_busy_i) state_d = S_ARB;
      default:     state_d = S_ARB;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    last_d      = last_q;
    lock_d      = lock_q;
    burst_d     = burst_q;
    tmo_d       = tmo_q;
    en_d        = 1'b0;
    data_d      = data_q;
    pen_d       = pen_q;
    psel_d      = psel_q;
    stop_d      = stop_q;
    grant_d     = grant_q;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    err_d       = err_q;
    burst_nx    = lock_eff ? (burst_q + 8'd1) : 8'd1;
    case (state_q)
      S_ARB: begin
        if (arb_en && win_vld) begin
          req_ready_o[win_idx] = 1'b1;
          data_d               = req_data_i[8*win_idx +: 8];
          pen_d                = cfg_parity_en_i;
          psel_d               = cfg_parity_sel_i;
          stop_d               = cfg_stop_sel_i;
          grant_d              = '0;
          grant_d[win_idx]     = 1'b1;
          last_d               = win_idx;
          burst_d              = burst_nx;
          lock_d               = req_lock_i[win_idx] && (burst_nx < MAX_BURST);
          en_d                 = 1'b1;
          tmo_d                = 4'd0;
        end else if (arb_en && lock_q && !req_lock_i[last_q]) begin
          lock_d = 1'b0;
        end
      end
      S_WAIT_BUSY: begin
        if (tx_busy_i) begin
          tmo_d = 4'd0;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d     = 4'd0;
          err_d     = 1'b1;
          done_d    = 1'b1;
          done_id_d = 3'(last_q);
          grant_d   = '0;
          lock_d    = 1'b0;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      S_WAIT_DONE: begin
        // Data and cfg stay frozen here: uart_tx reads data_i for the parity bit.
        if (!tx_busy_i) begin
          done_d    = 1'b1;
          done_id_d = 3'(last_q);
          grant_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign tx_enable_o     = en_q;
  assign tx_data_o       = data_q;
  assign tx_parity_en_o  = pen_q;
  assign tx_parity_sel_o = psel_q;
  assign tx_stop_sel_o   = stop_q;
  assign grant_o         = grant_q;
  assign done_o          = done_q;
  assign done_id_o       = done_id_q;
  assign err_o           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_sched: self-checking bench for uart_tx_sched with a uart_tx model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_sched;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   valid = '0;
  logic [N-1:0]   lock  = '0;
  logic [8*N-1:0] data  = '0;
  logic pen = 1'b0, psel = 1'b0, stop = 1'b0;
  logic stub = 1'b0;

  logic [N-1:0] rdy_a, rdy_b, grant_a, grant_b;
  logic en_a, en_b, pe_a, pe_b, ps_a, ps_b, st_a, st_b;
  logic done_a, done_b, err_a, err_b;
  logic [7:0] d_a, d_b;
  logic [2:0] id_a, id_b;
  logic [1:0] busy = 2'b00;
  int m_pos[2];
  int m_len[2];
  logic line_a;
  logic [7:0] held;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_sched #(.p_num_req(N), .p_max_burst(16), .p_start_timeout(4)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_data_i(data), .req_lock_i(lock),
    .req_ready_o(rdy_a), .cfg_parity_en_i(pen), .cfg_parity_sel_i(psel), .cfg_stop_sel_i(stop),
    .tx_enable_o(en_a), .tx_data_o(d_a), .tx_parity_en_o(pe_a), .tx_parity_sel_o(ps_a),
    .tx_stop_sel_o(st_a), .tx_busy_i(busy[0]), .grant_o(grant_a), .done_o(done_a),
    .done_id_o(id_a), .err_o(err_a));

  uart_tx_sched #(.p_num_req(N), .p_max_burst(2), .p_start_timeout(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_data_i(data), .req_lock_i(lock),
    .req_ready_o(rdy_b), .cfg_parity_en_i(pen), .cfg_parity_sel_i(psel), .cfg_stop_sel_i(stop),
    .tx_enable_o(en_b), .tx_data_o(d_b), .tx_parity_en_o(pe_b), .tx_parity_sel_o(ps_b),
    .tx_stop_sel_o(st_b), .tx_busy_i(busy[1]), .grant_o(grant_b), .done_o(done_b),
    .done_id_o(id_b), .err_o(err_b));

  // uart_tx stand-in: one bit per clock, busy rises the cycle after enable.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst || stub) begin
        busy[u]  <= 1'b0;
        m_pos[u] <= 0;
      end else if (busy[u]) begin
        if (m_pos[u] == m_len[u] - 1) busy[u] <= 1'b0;
        m_pos[u] <= m_pos[u] + 1;
      end else if ((u == 0) ? en_a : en_b) begin
        busy[u]  <= 1'b1;
        m_pos[u] <= 0;
        m_len[u] <= 10 + (((u == 0) ? pe_a : pe_b) ? 1 : 0) + (((u == 0) ? st_a : st_b) ? 1 : 0);
      end
    end
  end

  always_comb begin
    line_a = 1'b1;
    if (busy[0]) begin
      if (m_pos[0] == 0)                line_a = 1'b0;
      else if (m_pos[0] <= 8)           line_a = d_a[m_pos[0]-1];
      else if (m_pos[0] == 9 && pe_a)   line_a = ps_a ? ^d_a : ~^d_a;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) if (en_a) held <= d_a;
  always @(negedge clk) begin
    if (!rst) begin
      check("en_while_busy", {31'd0, en_a & busy[0]}, 32'd0);
      if (busy[0]) check("data_hold", {24'd0, d_a}, {24'd0, held});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_accept(input int u, output int id);
    logic [N-1:0] r;
    bit got;
    got = 0;
    id  = -1;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      r = (u == 0) ? rdy_a : rdy_b;
      if (r != '0) begin
        got = 1;
        for (int k = 0; k < N; k++) if (r[k]) id = k;
      end else begin
        tick();
      end
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int u, output int id);
    bit got;
    got = 0;
    id  = -1;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if ((u == 0) ? done_a : done_b) begin
        got = 1;
        id  = int'((u == 0) ? id_a : id_b);
      end else begin
        tick();
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [2:0]  cfg;
    int          exp_id;
    logic [7:0]  exp_byte;
  } vec_t;
  vec_t vt[12];

  // Random-phase reference state
  logic [7:0] rbuf[N][8];
  int rh[N];
  int last, holder, burst, w, remaining;
  bit locked, elig, pend, seen_done;
  int pend_id;
  logic [7:0] pend_byte;
  logic [2:0] pend_cfg;
  logic [N-1:0] exp_rdy;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int id;
    int exp_seq[3];
    bit found;

    vt[0]  = '{4'b0010, 32'h0000_A500, 3'b100,  1, 8'hA5};
    vt[1]  = '{4'b1111, 32'h4433_2211, 3'b110,  2, 8'h33};
    vt[2]  = '{4'b1111, 32'h8877_6655, 3'b001,  3, 8'h88};
    vt[3]  = '{4'b1111, 32'hCCBB_AA99, 3'b111,  0, 8'h99};
    vt[4]  = '{4'b1111, 32'h1020_3040, 3'b010,  1, 8'h30};
    vt[5]  = '{4'b1001, 32'hDE00_00EF, 3'b101,  3, 8'hDE};
    vt[6]  = '{4'b0110, 32'h005A_3C00, 3'b000,  1, 8'h3C};
    vt[7]  = '{4'b0001, 32'h0000_007E, 3'b011,  0, 8'h7E};
    vt[8]  = '{4'b1000, 32'hF000_0000, 3'b100,  3, 8'hF0};
    vt[9]  = '{4'b0100, 32'h000F_0000, 3'b110,  2, 8'h0F};
    vt[10] = '{4'b0101, 32'h0012_0034, 3'b001,  0, 8'h34};
    vt[11] = '{4'b0101, 32'h0056_0078, 3'b111,  2, 8'h56};

    // Reset values, with requests pending to show ready is held off.
    valid = 4'b1111;
    tick();
    tick();
    check("rst_ready",  {28'd0, rdy_a}, 32'd0);
    check("rst_tx",     {20'd0, en_a, d_a, pe_a, ps_a, st_a}, 32'd0);
    check("rst_status", {23'd0, grant_a, done_a, id_a, err_a}, 32'd0);
    valid = '0;
    rst   = 1'b0;
    tick();

    // Table-driven single frames
    for (int i = 0; i < 12; i++) begin
      valid = vt[i].valid;
      data  = vt[i].data;
      {pen, psel, stop} = vt[i].cfg;
      wait_accept(0, id);
      check("vec_ready", {28'd0, rdy_a}, 32'd1 << vt[i].exp_id);
      tick();
      valid = '0;
      @(negedge clk);
      check("vec_enable", {31'd0, en_a}, 32'd1);
      check("vec_data",   {24'd0, d_a}, {24'd0, vt[i].exp_byte});
      check("vec_cfg",    {29'd0, pe_a, ps_a, st_a}, {29'd0, vt[i].cfg});
      check("vec_grant",  {28'd0, grant_a}, 32'd1 << vt[i].exp_id);
      tick();
      @(negedge clk);
      check("vec_en_pulse", {31'd0, en_a}, 32'd0);
      tick();
      wait_done(0, id);
      check("vec_done_id", 32'(id), 32'(vt[i].exp_id));
      check("vec_grant_clr", {28'd0, grant_a}, 32'd0);
      tick();
    end

    // Fairness with all requesters held valid
    do_reset();
    valid = 4'b1111;
    data  = 32'h4433_2211;
    for (int i = 0; i < 8; i++) begin
      wait_accept(0, id);
      check("fair_order", 32'(id), 32'(i % 4));
      tick();
      wait_done(0, id);
      tick();
    end
    valid = '0;

    // Lock: requester 2 keeps the grant for three bytes, then 0 gets its turn
    do_reset();
    for (int n = 0; n < 4; n++) begin
      valid = (n == 0) ? 4'b0100 : 4'b0101;
      lock  = (n < 3)  ? 4'b0100 : 4'b0000;
      wait_accept(0, id);
      check("lock_order", 32'(id), (n < 3) ? 32'd2 : 32'd0);
      tick();
      wait_done(0, id);
      tick();
    end
    valid = '0;
    lock  = '0;

    // Burst limit of 2 forces release to the next requester
    do_reset();
    exp_seq = '{2, 2, 3};
    valid = 4'b1100;
    lock  = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      wait_accept(1, id);
      check("burst_order", 32'(id), 32'(exp_seq[n]));
      tick();
      wait_done(1, id);
      tick();
    end
    valid = '0;
    lock  = '0;

    // Start timeout: busy never rises
    do_reset();
    stub  = 1'b1;
    valid = 4'b0001;
    wait_accept(0, id);
    tick();
    valid = '0;
    @(negedge clk);
    check("tmo_enable", {31'd0, en_a}, 32'd1);
    tick();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("tmo_wait", {30'd0, err_a, done_a}, 32'd0);
      tick();
    end
    @(negedge clk);
    check("tmo_fire",  {28'd0, err_a, done_a, grant_a == '0, id_a == 3'd0}, 32'hF);
    tick();
    @(negedge clk);
    check("tmo_sticky", {30'd0, err_a, done_a}, 32'd2);
    tick();
    valid = 4'b0010;
    @(negedge clk);
    check("tmo_rearb", {28'd0, rdy_a}, 32'd2);
    valid = '0;
    stub  = 1'b0;
    tick();

    // Parity bit generated from the held byte while the requester data changes
    do_reset();
    valid = 4'b0001;
    data  = 32'h0000_0001;
    {pen, psel, stop} = 3'b110;
    wait_accept(0, id);
    tick();
    valid = '0;
    data  = 32'hFFFF_FFFF;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (busy[0] && m_pos[0] == 9) begin
        found = 1;
        check("par_line", {31'd0, line_a}, 32'd1);
        check("par_data", {24'd0, d_a}, 32'h01);
      end
      tick();
    end
    check("par_seen", {31'd0, found}, 32'd1);
    wait_done(0, id);
    tick();

    // Reset mid-frame
    valid = 4'b0100;
    data  = 32'h005C_0000;
    {pen, psel, stop} = 3'b111;
    wait_accept(0, id);
    tick();
    valid = '0;
    for (int c = 0; c < 6; c++) tick();
    check("mid_in_frame", {31'd0, busy[0]}, 32'd1);
    valid = 4'b1111;
    rst   = 1'b1;
    #1;
    check("mid_rst_tx",     {20'd0, en_a, d_a, pe_a, ps_a, st_a}, 32'd0);
    check("mid_rst_status", {23'd0, grant_a, done_a, id_a, err_a}, 32'd0);
    check("mid_rst_ready",  {28'd0, rdy_a}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_first_grant", {28'd0, rdy_a}, 32'd1);
    valid = '0;
    tick();

    // Randomised traffic against the arbitration rules
    do_reset();
    for (int k = 0; k < N; k++) begin
      rh[k] = 0;
      for (int j = 0; j < 8; j++) rbuf[k][j] = 8'($urandom);
    end
    remaining = 8 * N;
    last = N - 1; holder = 0; burst = 0; locked = 0; elig = 1; pend = 0;
    for (int cyc = 0; cyc < 3000 && (remaining > 0 || pend); cyc++) begin
      for (int k = 0; k < N; k++) begin
        valid[k]        = (rh[k] < 8) && ($urandom_range(0, 3) != 0);
        data[8*k +: 8]  = (rh[k] < 8) ? rbuf[k][rh[k]] : 8'h00;
        lock[k]         = ($urandom_range(0, 2) != 0);
      end
      {pen, psel, stop} = 3'($urandom);
      seen_done = 0;
      @(negedge clk);
      exp_rdy = '0;
      if (elig) begin
        if (locked && !lock[holder]) locked = 0;
        w = -1;
        if (locked) begin
          if (valid[holder]) w = holder;
        end else begin
          for (int i = 1; i <= N; i++) if (w < 0 && valid[(last + i) % N]) w = (last + i) % N;
        end
        if (w >= 0) begin
          exp_rdy[w] = 1'b1;
          burst      = locked ? burst + 1 : 1;
          locked     = lock[w] && (burst < 16);
          holder     = w;
          last       = w;
          pend       = 1;
          pend_id    = w;
          pend_byte  = rbuf[w][rh[w]];
          pend_cfg   = {pen, psel, stop};
          rh[w]++;
          remaining--;
          elig       = 0;
        end
      end
      check("rand_ready", {28'd0, rdy_a}, {28'd0, exp_rdy});
      if (en_a) begin
        check("rand_data",  {24'd0, d_a}, {24'd0, pend_byte});
        check("rand_cfg",   {29'd0, pe_a, ps_a, st_a}, {29'd0, pend_cfg});
        check("rand_grant", {28'd0, grant_a}, 32'd1 << pend_id);
      end
      if (done_a) begin
        check("rand_done_id", {29'd0, id_a}, 32'(pend_id));
        pend      = 0;
        seen_done = 1;
      end
      tick();
      if (seen_done) elig = 1;
    end
    check("rand_drained", 32'(remaining), 32'd0);
    check("rand_no_err", {31'd0, err_a}, 32'd0);
    valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
